// File: rtl/triangle_assembler.sv
// Groups accepted vertices into triangle records and queues them in a FWFT FIFO
// toward the rasteriser. Optional degenerate-triangle culling: TRI_ASM_CULL_EN.
module triangle_assembler #(
  parameter int FIFO_DEPTH = 4,
  parameter int ERR_W      = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [47:0]                   vertex_in,
  input  logic [15:0]                   color_in,
  input  logic                          new_triangle_in,
  input  logic                          active_in,
  output logic                          tri_valid,
  input  logic                          tri_ready,
  output logic [47:0]                   tri_v0,
  output logic [47:0]                   tri_v1,
  output logic [47:0]                   tri_v2,
  output logic [15:0]                   tri_color,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  output logic [ERR_W-1:0]              err_count,
  output logic [ERR_W-1:0]              cull_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int REC_W = 3 * 48 + 16;

  typedef enum logic [1:0] {WAIT0, GOT1, GOT2} state_t;

  state_t      state, state_next;
  logic [47:0] v0_r, v1_r;
  logic [15:0] color_r;
  logic        cap_v0, cap_v1, abort, complete, push_req;

  // Vertex grouping FSM
  always_comb begin
    state_next = state;
    cap_v0     = 1'b0;
    cap_v1     = 1'b0;
    abort      = 1'b0;
    complete   = 1'b0;
    if (active_in) begin
      case (state)
        WAIT0: begin
          if (new_triangle_in) begin
            cap_v0     = 1'b1;
            state_next = GOT1;
          end
        end
        GOT1: begin
          if (new_triangle_in) begin
            abort      = 1'b1;
            cap_v0     = 1'b1;
            state_next = GOT1;
          end else begin
            cap_v1     = 1'b1;
            state_next = GOT2;
          end
        end
        GOT2: begin
          if (new_triangle_in) begin
            abort      = 1'b1;
            cap_v0     = 1'b1;
            state_next = GOT1;
          end else begin
            complete   = 1'b1;
            state_next = WAIT0;
          end
        end
        default: state_next = WAIT0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= WAIT0;
      v0_r    <= '0;
      v1_r    <= '0;
      color_r <= '0;
    end else begin
      state <= state_next;
      if (cap_v0) begin
        v0_r    <= vertex_in;
        color_r <= color_in;
      end
      if (cap_v1) v1_r <= vertex_in;
    end
  end

`ifdef TRI_ASM_CULL_EN
  logic degenerate;
  assign degenerate = (v0_r == v1_r) || (v1_r == vertex_in) || (v0_r == vertex_in);
  assign push_req   = complete && !degenerate;

  always_ff @(posedge clk) begin
    if (rst) begin
      cull_count <= '0;
    end else if (complete && degenerate && (cull_count != '1)) begin
      cull_count <= cull_count + ERR_W'(1);
    end
  end
`else
  assign push_req   = complete;
  assign cull_count = '0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      err_count <= '0;
    end else if (abort && (err_count != '1)) begin
      err_count <= err_count + ERR_W'(1);
    end
  end

  // The completed record is staged one cycle before entering the FIFO, which
  // gives the two-edge vertex-to-valid latency; full/drop is judged at write time.
  logic             stg_valid;
  logic [REC_W-1:0] stg_rec;

  always_ff @(posedge clk) begin
    if (rst) begin
      stg_valid <= 1'b0;
      stg_rec   <= '0;
    end else begin
      stg_valid <= push_req;
      if (push_req) stg_rec <= {v0_r, v1_r, vertex_in, color_r};
    end
  end

  logic [REC_W-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full, pop, wr_en, drop;

  assign full  = (count == CNT_W'(FIFO_DEPTH));
  assign pop   = tri_valid && tri_ready;
  assign wr_en = stg_valid && (!full || pop);
  assign drop  = stg_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr] <= stg_rec;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  assign tri_valid  = (count != '0);
  assign fifo_count = count;
  assign {tri_v0, tri_v1, tri_v2, tri_color} = mem[rd_ptr];

endmodule
